// File: rtl/imm_gen_pkg.sv
// Shared opcode constants and immediate-format encoding for the RISC-V decode-stage
// immediate generator.
package imm_gen_pkg;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    typedef enum logic [2:0] {
        FmtR    = 3'd0,
        FmtI    = 3'd1,
        FmtS    = 3'd2,
        FmtB    = 3'd3,
        FmtU    = 3'd4,
        FmtJ    = 3'd5,
        FmtNone = 3'd7
    } imm_fmt_t;

    function automatic imm_fmt_t opcode_fmt(input logic [6:0] opc);
        imm_fmt_t f;
        case (opc)
            OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR: f = FmtI;
            OPC_STORE:                                 f = FmtS;
            OPC_BRANCH:                                f = FmtB;
            OPC_LUI, OPC_AUIPC:                        f = FmtU;
            OPC_JAL:                                   f = FmtJ;
            OPC_OP, OPC_OP32:                          f = FmtR;
            default:                                   f = FmtNone;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_format_decode.sv
// Combinational immediate decoder: opcode -> format, illegal flag and sign-extended
// immediate.
module imm_format_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_t        fmt,
    output logic            illegal
);

    // Built at 64 bits and truncated, so XLEN=32 needs no special casing.
    logic [63:0] imm64;

    always_comb begin
        fmt     = opcode_fmt(instr[6:0]);
        illegal = (fmt == FmtNone);
        imm64   = '0;
        case (fmt)
            FmtI: imm64 = {{52{instr[31]}}, instr[31:20]};
            FmtS: imm64 = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            FmtB: imm64 = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
            FmtU: imm64 = {{32{instr[31]}}, instr[31:12], 12'b0};
            FmtJ: imm64 = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
            default: imm64 = '0;
        endcase
    end

    assign imm = imm64[XLEN-1:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode on the input side, 2-entry skid buffer with
// valid/ready handshake, flush and synchronous reset on the output side.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] dec_imm;
    imm_fmt_t        dec_fmt;
    logic            dec_illegal;

    imm_format_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .instr  (in_instr),
        .imm    (dec_imm),
        .fmt    (dec_fmt),
        .illegal(dec_illegal)
    );

    // Slot 0 is always the head; slot 1 only holds data when count is 2.
    logic [1:0]       count_q, count_d;
    logic [XLEN-1:0]  imm_q [2];
    logic [XLEN-1:0]  imm_d [2];
    imm_fmt_t         fmt_q [2];
    imm_fmt_t         fmt_d [2];
    logic             ill_q [2];
    logic             ill_d [2];
    logic [TAG_W-1:0] tag_q [2];
    logic [TAG_W-1:0] tag_d [2];

    logic push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        for (int i = 0; i < 2; i++) begin
            imm_d[i] = imm_q[i];
            fmt_d[i] = fmt_q[i];
            ill_d[i] = ill_q[i];
            tag_d[i] = tag_q[i];
        end

        if (flush) begin
            count_d = 2'd0;
        end else begin
            unique case (count_q)
                2'd0: begin
                    if (push) begin
                        imm_d[0] = dec_imm;
                        fmt_d[0] = dec_fmt;
                        ill_d[0] = dec_illegal;
                        tag_d[0] = in_tag;
                        count_d  = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        imm_d[0] = dec_imm;
                        fmt_d[0] = dec_fmt;
                        ill_d[0] = dec_illegal;
                        tag_d[0] = in_tag;
                    end else if (push) begin
                        imm_d[1] = dec_imm;
                        fmt_d[1] = dec_fmt;
                        ill_d[1] = dec_illegal;
                        tag_d[1] = in_tag;
                        count_d  = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        imm_d[0] = imm_q[1];
                        fmt_d[0] = fmt_q[1];
                        ill_d[0] = ill_q[1];
                        tag_d[0] = tag_q[1];
                        count_d  = 2'd1;
                    end
                end
                default: count_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                imm_q[i] <= '0;
                fmt_q[i] <= FmtNone;
                ill_q[i] <= 1'b0;
                tag_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < 2; i++) begin
                imm_q[i] <= imm_d[i];
                fmt_q[i] <= fmt_d[i];
                ill_q[i] <= ill_d[i];
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign out_imm     = imm_q[0];
    assign out_fmt     = fmt_q[0];
    assign out_illegal = ill_q[0];
    assign out_tag     = tag_q[0];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=64 instance plus an XLEN=32 instance fed the
// same stimulus.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_tag;

    logic        in_ready, out_valid, out_illegal;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic [31:0] out_tag;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic [31:0] out_tag32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_imm    (out_imm),
        .out_fmt    (out_fmt),
        .out_illegal(out_illegal),
        .out_tag    (out_tag)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready32),
        .in_instr   (in_instr),
        .in_tag     (in_tag),
        .out_valid  (out_valid32),
        .out_ready  (out_ready),
        .out_imm    (out_imm32),
        .out_fmt    (out_fmt32),
        .out_illegal(out_illegal32),
        .out_tag    (out_tag32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [63:0] imm64, input logic [31:0] imm32,
                            input logic [2:0] fmt, input logic ill, input logic [31:0] t);
        chk({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, ".imm"}, out_imm, imm64);
        chk({tag, ".fmt"}, {61'd0, out_fmt}, {61'd0, fmt});
        chk({tag, ".illegal"}, {63'd0, out_illegal}, {63'd0, ill});
        chk({tag, ".tag"}, {32'd0, out_tag}, {32'd0, t});
        chk({tag, ".imm32"}, {32'd0, out_imm32}, {32'd0, imm32});
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, ".ready"}, {63'd0, in_ready}, 64'd1);
        chk({tag, ".valid32"}, {63'd0, out_valid32}, 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_empty(tag);
        chk({tag, ".imm"}, out_imm, 64'd0);
        chk({tag, ".fmt"}, {61'd0, out_fmt}, 64'd7);
        chk({tag, ".illegal"}, {63'd0, out_illegal}, 64'd0);
        chk({tag, ".tag"}, {32'd0, out_tag}, 64'd0);
        chk({tag, ".imm32"}, {32'd0, out_imm32}, 64'd0);
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] t);
        in_valid = v;
        in_instr = instr;
        in_tag   = t;
    endtask

    // Hand-decoded vectors: I(-1), S(-4), B(-8), J(0x800), U(0x80000000), illegal, R,
    // lw 8, auipc, jalr -4, jal -4, beq +8.
    logic [31:0] v_instr [12] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h001000EF,
                                  32'h800002B7, 32'h0000007F, 32'h002081B3, 32'h00812103,
                                  32'h12345017, 32'hFFC08067, 32'hFFDFF06F, 32'h00000463};
    logic [63:0] v_imm [12] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
                                64'hFFFFFFFFFFFFFFF8, 64'h0000000000000800,
                                64'hFFFFFFFF80000000, 64'h0, 64'h0, 64'h8,
                                64'h0000000012345000, 64'hFFFFFFFFFFFFFFFC,
                                64'hFFFFFFFFFFFFFFFC, 64'h8};
    logic [31:0] v_imm32 [12] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000800,
                                  32'h80000000, 32'h0, 32'h0, 32'h8, 32'h12345000,
                                  32'hFFFFFFFC, 32'hFFFFFFFC, 32'h8};
    logic [2:0] v_fmt [12] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd7, 3'd0, 3'd1, 3'd4,
                               3'd1, 3'd5, 3'd3};
    logic v_ill [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                         1'b0, 1'b0};

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;

        // Streaming, one per cycle with out_ready held high.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, v_instr[i], 32'h100 + i);
            @(negedge clk);
            chk_head("vec", v_imm[i], v_imm32[i], v_fmt[i], v_ill[i], 32'h100 + i);
            chk("vec.in_ready", {63'd0, in_ready}, 64'd1);
        end
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk_empty("drain");

        // Backpressure: third offer must stall, head must hold, order must survive.
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 32'h200);
        @(negedge clk);
        chk_head("bp.x0a", 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 3'd1, 1'b0, 32'h200);
        chk("bp.ready1", {63'd0, in_ready}, 64'd1);
        drive(1'b1, 32'hFE112E23, 32'h201);
        @(negedge clk);
        chk_head("bp.x0b", 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 3'd1, 1'b0, 32'h200);
        chk("bp.ready2", {63'd0, in_ready}, 64'd0);
        drive(1'b1, 32'h800002B7, 32'h202);
        @(negedge clk);
        chk_head("bp.x0c", 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 3'd1, 1'b0, 32'h200);
        chk("bp.ready3", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk_head("bp.x1", 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 3'd2, 1'b0, 32'h201);
        chk("bp.ready4", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        chk_head("bp.x2", 64'hFFFFFFFF80000000, 32'h80000000, 3'd4, 1'b0, 32'h202);
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk_empty("bp.drain");

        // Flush with a full buffer and an input offered in the same cycle.
        out_ready = 1'b0;
        drive(1'b1, 32'h00812103, 32'h300);
        @(negedge clk);
        drive(1'b1, 32'h12345017, 32'h301);
        @(negedge clk);
        chk("fl.full", {63'd0, in_ready}, 64'd0);
        flush = 1'b1;
        drive(1'b1, 32'hFFC08067, 32'h302);
        @(negedge clk);
        chk_empty("fl.full.after");
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk_empty("fl.full.quiet");

        // Flush with one entry: in_ready is high but the offered input is still dropped.
        drive(1'b1, 32'hFE000CE3, 32'h400);
        @(negedge clk);
        chk_head("fl.one", 64'hFFFFFFFFFFFFFFF8, 32'hFFFFFFF8, 3'd3, 1'b0, 32'h400);
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h001000EF, 32'h401);
        @(negedge clk);
        chk_empty("fl.one.after");
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk_empty("fl.one.quiet");
        drive(1'b1, 32'h00000463, 32'h402);
        @(negedge clk);
        chk_head("fl.resume", 64'h8, 32'h8, 3'd3, 1'b0, 32'h402);
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);

        // Reset mid-stream with a full buffer and an input offered.
        out_ready = 1'b0;
        drive(1'b1, 32'h0000007F, 32'h500);
        @(negedge clk);
        drive(1'b1, 32'h002081B3, 32'h501);
        @(negedge clk);
        chk("rs.full", {63'd0, in_ready}, 64'd0);
        reset = 1'b1;
        flush = 1'b1;
        drive(1'b1, 32'hFFF00093, 32'h502);
        @(negedge clk);
        chk_reset_vals("rs.after");
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk_reset_vals("rs.quiet");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, registered immediate generator for the decode stage of the pipelined RISC-V core.
- Decodes all base formats (I, S, B, U, J, R) from the full 7-bit opcode.
- Produces an XLEN-wide sign-extended, byte-offset-correct immediate, with a format code and an illegal-opcode flag.
- Sits behind a 2-entry skid buffer with valid/ready handshake and a flush input for hazard/branch recovery.

Parameters:
- XLEN, 64, immediate output width; legal values 32 or 64; any other value is an elaboration error.
- TAG_W, 32, width of the sideband tag (PC or pipeline ID) carried alongside each instruction.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous flush; drops all buffered entries.
- in_valid  in  1  instruction present on in_instr/in_tag.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  32  raw instruction word.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  out_imm/out_fmt/out_illegal/out_tag valid.
- out_ready  in  1  consumer accepts this cycle.
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=NONE.
- out_illegal  out  1  opcode not in the supported set.
- out_tag  out  TAG_W  tag of the head entry.

Behaviour:
- Opcode map (instr[6:0]):
  - I: 0000011, 0010011, 0011011, 1100111
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - R: 0110011, 0111011
  - Anything else: fmt=NONE, illegal=1, imm=0.
- Immediate construction, then sign-extended from the top bit to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} (13 bits, bit0 forced 0).
  - U: {instr[31:12], 12'b0} (32 bits).
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} (21 bits).
  - R: imm=0, illegal=0.
- XLEN=32 truncates nothing; U/J values fit in 32 bits.
- Decode is combinational on the input side. The result is written into the skid buffer on accept (in_valid && in_ready).
- Buffer: 2 entries, FIFO order, count in {0,1,2}.
  - in_ready = (count != 2), driven from registered count only (no combinational path from out_ready).
  - Push when in_valid && in_ready; pop when out_valid && out_ready.
- Latency: an accepted instruction appears on out_* the cycle after acceptance when the buffer was empty.
- Throughput: 1 per cycle while out_ready stays high.
- out_valid = (count != 0); out_* always show the head entry.
- Head entry data is held stable while out_valid && !out_ready.
- Simultaneous push and pop:
  - count=1: count stays 1; the new entry becomes head on the next cycle.
  - count=2: push is impossible (in_ready=0), pop gives count=1.
- flush:
  - Next cycle count=0, out_valid=0, in_ready=1.
  - An input offered in the flush cycle is discarded, even if in_ready was high.
  - A pop in the same cycle is still considered taken by the consumer.
- reset has priority over flush. Next cycle:
  - count=0, out_valid=0, in_ready=1.
  - out_imm=0, out_fmt=7, out_illegal=0, out_tag=0.
  - Reset mid-stream discards all entries.
- Data registers of empty entries need not clear except on reset.

Decomposition:
- Package imm_gen_pkg holds:
  - opcode constants (OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_OP32);
  - the 3-bit format enum imm_fmt_t.
- One combinational sub-module imm_format_decode:
  - inputs: instr;
  - outputs: imm[XLEN-1:0], fmt, illegal.
- The top level holds only the skid buffer and handshake.

Test Plan:
- Reset, then send 0xFFF00093 with out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFFFFFFFFFF, out_fmt=1.
- Back-to-back 0xFE112E23, 0xFE000CE3, 0x001000EF -> out_imm=-4 (S), -8 (B), 0x800 (J), one per cycle, in order.
- 0x800002B7 with XLEN=64 -> out_imm=0xFFFFFFFF80000000, fmt=4. With XLEN=32 -> 0x80000000.
- Hold out_ready=0 and offer 3 instructions -> in_ready drops after 2 accepts, head data stable. Release -> all emerge in order, none lost or duplicated.
- Opcode 0x0000007F -> fmt=7, illegal=1, imm=0. Opcode 0x002081B3 (add) -> fmt=0, illegal=0, imm=0.
- With count=2, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, flushed-cycle input never appears. Repeat the sequence with reset -> outputs at reset values.
